// File: rtl/jtag_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_bridge_pkg
//  Purpose  : Shared definitions for the JTAG burst bridge. Holds the virtual-IR
//             instruction codes, the REG_OP status-byte bit positions, the
//             register index that clears the sticky error, and a helper that
//             assembles the status byte.
//  Revision : 1.0 - initial release
// ============================================================================
package jtag_bridge_pkg;

    // Virtual IR instruction codes. Code 3'b111 is deliberately absent and is
    // decoded as BYPASS by the bridge.
    typedef enum logic [2:0] {
        INS_BYPASS    = 3'b000,
        INS_REG_OP    = 3'b001,
        INS_READ_MEM  = 3'b010,
        INS_WRITE_MEM = 3'b011,
        INS_SET_PTR   = 3'b100,
        INS_BURST_WR  = 3'b101,
        INS_BURST_RD  = 3'b110
    } jtag_ins_e;

    // Bit positions inside the REG_OP capture byte
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    // REG_OP index that clears the sticky error instead of writing a register
    localparam logic [7:0] REG_CLR_ERR = 8'hFF;

    function automatic logic [7:0] status_byte(input logic err,
                                               input logic done,
                                               input logic busy);
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_ERR_BIT]  = err;
        s[STAT_DONE_BIT] = done;
        s[STAT_BUSY_BIT] = busy;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_mmio_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_mmio_regfile
//  Purpose  : NREGS x 8-bit configuration register file with a single write
//             port, flattened read-out and start_pulse generation.
//  Ports    : tck, aclr           - clock, async active-low reset
//             wr_en/wr_idx/wr_data - write port (idx must be < NREGS to act)
//             cfg_regs            - reg i at [8i+7:8i]
//             start_pulse         - one-tck pulse, coincident with the update
//                                   of reg START_IDX when written with bit0=1
//  Revision : 1.0 - initial release
// ============================================================================
module jtag_mmio_regfile
    import jtag_bridge_pkg::*;
#(
    parameter int NREGS     = 16,
    parameter int START_IDX = 6
)(
    input  logic               tck,
    input  logic               aclr,
    input  logic               wr_en,
    input  logic [7:0]         wr_idx,
    input  logic [7:0]         wr_data,
    output logic [NREGS*8-1:0] cfg_regs,
    output logic               start_pulse
);

    logic [7:0] r_regs [NREGS];
    logic       r_start_pulse;

    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_start_pulse <= 1'b0;
        end else begin
            // Pulse is registered alongside the register itself so software
            // sees the new value and the pulse in the same tck.
            r_start_pulse <= wr_en && (wr_idx == 8'(START_IDX)) && wr_data[0];
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en && (wr_idx == 8'(i))) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_flat
            assign cfg_regs[8*g +: 8] = r_regs[g];
        end
    endgenerate

    assign start_pulse = r_start_pulse;

endmodule

`default_nettype wire

// File: rtl/jtag_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_burst_bridge
//  Purpose  : Virtual-JTAG to memory / config-register bridge with single-word
//             access plus an auto-incrementing pointer for burst streaming.
//             Everything runs on tck.
//  Ports    : tck, aclr                   - clock, async active-low reset
//             tdi, tdo                    - serial data in / out
//             ir_in, v_sdr/v_cdr/v_udr/v_uir - virtual IR and state qualifiers
//             mem_we/mem_addr/mem_wdata   - memory write port (addr also read)
//             mem_rdata                   - read data, one tck after mem_addr
//             hw_busy, hw_done            - datapath status for REG_OP capture
//             cfg_regs, start_pulse       - register file outputs
//  Revision : 1.0 - initial release
// ============================================================================
module jtag_burst_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int NREGS     = 16,
    parameter int START_IDX = 6
)(
    input  logic               tck,
    input  logic               aclr,
    input  logic               tdi,
    input  logic [2:0]         ir_in,
    input  logic               v_sdr,
    input  logic               v_cdr,
    input  logic               v_udr,
    input  logic               v_uir,
    output logic               tdo,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               hw_busy,
    input  logic               hw_done,
    output logic [NREGS*8-1:0] cfg_regs,
    output logic               start_pulse
);

    localparam int                  C_MEM_DR_W  = ADDR_W + DATA_W;
    localparam int                  C_BCNT_W    = $clog2(DATA_W);
    // 2^ADDR_W - NREGS, formed without needing a wider-than-ADDR_W constant
    localparam logic [ADDR_W-1:0]   C_MMIO_BASE = {ADDR_W{1'b1}} - ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0]   C_PTR_LAST  = C_MMIO_BASE - ADDR_W'(1);
    localparam logic [C_BCNT_W-1:0] C_BCNT_LAST = C_BCNT_W'(DATA_W - 1);
    localparam logic [8:0]          C_NREGS     = 9'(NREGS);

    jtag_ins_e             w_ir;

    logic                  r_bypass;
    logic [15:0]           r_reg_dr;
    logic [C_MEM_DR_W-1:0] r_mem_dr;
    logic [ADDR_W-1:0]     r_ptr_dr;
    logic [DATA_W-1:0]     r_burst_dr;
    logic [ADDR_W-1:0]     r_ptr;
    logic [C_BCNT_W-1:0]   r_bcnt;
    logic                  r_err;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [DATA_W-1:0]     r_wdata;

    logic [ADDR_W-1:0]     w_mem_addr_fld;
    logic [DATA_W-1:0]     w_mem_data_fld;
    logic [ADDR_W-1:0]     w_ptr_inc;
    logic                  w_ptr_wrap;
    logic                  w_word_done;
    logic [DATA_W-1:0]     w_burst_word;
    logic                  w_rf_we;
    logic [7:0]            w_rf_idx;
    logic [7:0]            w_rf_data;

    assign w_ir           = jtag_ins_e'(ir_in);
    assign w_mem_addr_fld = r_mem_dr[C_MEM_DR_W-1:DATA_W];
    assign w_mem_data_fld = r_mem_dr[DATA_W-1:0];

    // Pointer never enters the MMIO window: stepping off its top wraps to 0
    assign w_ptr_wrap   = (r_ptr == C_PTR_LAST);
    assign w_ptr_inc    = w_ptr_wrap ? '0 : r_ptr + ADDR_W'(1);
    assign w_word_done  = v_sdr && (r_bcnt == C_BCNT_LAST);
    assign w_burst_word = {tdi, r_burst_dr[DATA_W-1:1]};

    // Register-file write port: REG_OP update or WRITE_MEM into the MMIO window
    always_comb begin
        w_rf_we   = 1'b0;
        w_rf_idx  = r_reg_dr[15:8];
        w_rf_data = r_reg_dr[7:0];
        if (v_udr) begin
            if (w_ir == INS_REG_OP) begin
                w_rf_we = ({1'b0, r_reg_dr[15:8]} < C_NREGS);
            end else if (w_ir == INS_WRITE_MEM && w_mem_addr_fld >= C_MMIO_BASE) begin
                w_rf_we   = 1'b1;
                w_rf_idx  = 8'(w_mem_addr_fld - C_MMIO_BASE);
                w_rf_data = 8'(w_mem_data_fld);
            end
        end
    end

    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            r_bypass   <= 1'b0;
            r_reg_dr   <= '0;
            r_mem_dr   <= '0;
            r_ptr_dr   <= '0;
            r_burst_dr <= '0;
            r_ptr      <= '0;
            r_bcnt     <= '0;
            r_err      <= 1'b0;
            r_mem_we   <= 1'b0;
            r_wr_addr  <= '0;
            r_wdata    <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (v_uir) begin
                r_bcnt <= '0;
            end

            case (w_ir)
                INS_REG_OP: begin
                    if (v_cdr) begin
                        r_reg_dr[7:0] <= status_byte(r_err, hw_done, hw_busy);
                    end else if (v_sdr) begin
                        r_reg_dr <= {tdi, r_reg_dr[15:1]};
                    end else if (v_udr && r_reg_dr[15:8] == REG_CLR_ERR) begin
                        r_err <= 1'b0;
                    end
                end

                INS_READ_MEM, INS_WRITE_MEM: begin
                    if (v_cdr) begin
                        r_mem_dr[DATA_W-1:0] <= mem_rdata;
                    end else if (v_sdr) begin
                        r_mem_dr <= {tdi, r_mem_dr[C_MEM_DR_W-1:1]};
                    end else if (v_udr && w_ir == INS_WRITE_MEM &&
                                 w_mem_addr_fld < C_MMIO_BASE) begin
                        r_mem_we  <= 1'b1;
                        r_wr_addr <= w_mem_addr_fld;
                        r_wdata   <= w_mem_data_fld;
                    end
                end

                INS_SET_PTR: begin
                    if (v_cdr) begin
                        r_ptr_dr <= r_ptr;          // lets the host read ptr back
                    end else if (v_sdr) begin
                        r_ptr_dr <= {tdi, r_ptr_dr[ADDR_W-1:1]};
                    end else if (v_udr) begin
                        if (r_ptr_dr >= C_MMIO_BASE) begin
                            r_ptr <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr_dr;
                        end
                    end
                end

                INS_BURST_WR: begin
                    if (v_cdr) begin
                        r_bcnt <= '0;
                    end else if (v_sdr) begin
                        r_burst_dr <= w_burst_word;
                        if (w_word_done) begin
                            r_bcnt    <= '0;
                            r_mem_we  <= (r_ptr < C_MMIO_BASE);
                            r_wr_addr <= r_ptr;
                            r_wdata   <= w_burst_word;
                            r_ptr     <= w_ptr_inc;
                            if (w_ptr_wrap) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_bcnt <= r_bcnt + C_BCNT_W'(1);
                        end
                    end
                end

                INS_BURST_RD: begin
                    // Loading a word advances ptr, so mem_rdata for the next
                    // word has DATA_W tcks to settle before it is needed.
                    if (v_cdr || w_word_done) begin
                        r_burst_dr <= mem_rdata;
                        r_bcnt     <= '0;
                        r_ptr      <= w_ptr_inc;
                        if (w_ptr_wrap) begin
                            r_err <= 1'b1;
                        end
                    end else if (v_sdr) begin
                        r_burst_dr <= {tdi, r_burst_dr[DATA_W-1:1]};
                        r_bcnt     <= r_bcnt + C_BCNT_W'(1);
                    end
                end

                default: begin              // BYPASS and the unused code 3'b111
                    if (v_cdr) begin
                        r_bypass <= 1'b0;
                    end else if (v_sdr) begin
                        r_bypass <= tdi;
                    end
                end
            endcase
        end
    end

    // A pending write owns the address bus for its single tck
    always_comb begin
        mem_addr = '0;
        if (r_mem_we) begin
            mem_addr = r_wr_addr;
        end else begin
            case (w_ir)
                INS_READ_MEM, INS_WRITE_MEM: mem_addr = w_mem_addr_fld;
                INS_BURST_WR, INS_BURST_RD:  mem_addr = r_ptr;
                default:                     mem_addr = '0;
            endcase
        end
    end

    always_comb begin
        tdo = r_bypass;
        case (w_ir)
            INS_REG_OP:                  tdo = r_reg_dr[0];
            INS_READ_MEM, INS_WRITE_MEM: tdo = r_mem_dr[0];
            INS_SET_PTR:                 tdo = r_ptr_dr[0];
            INS_BURST_WR, INS_BURST_RD:  tdo = r_burst_dr[0];
            default:                     tdo = r_bypass;
        endcase
    end

    assign mem_we    = r_mem_we;
    assign mem_wdata = r_wdata;

    jtag_mmio_regfile #(
        .NREGS     (NREGS),
        .START_IDX (START_IDX)
    ) u_regfile (
        .tck         (tck),
        .aclr        (aclr),
        .wr_en       (w_rf_we),
        .wr_idx      (w_rf_idx),
        .wr_data     (w_rf_data),
        .cfg_regs    (cfg_regs),
        .start_pulse (start_pulse)
    );

endmodule

`default_nettype wire

// File: tb/tb_jtag_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_burst_bridge
//  Purpose  : Self-checking bench for jtag_burst_bridge: REG_OP vector table
//             plus directed single-word, burst, wrap, MMIO and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_burst_bridge;

    localparam int          ADDR_W    = 19;
    localparam int          DATA_W    = 8;
    localparam int          NREGS     = 16;
    localparam int          START_IDX = 6;
    localparam logic [18:0] MMIO_BASE = 19'h7FFF0;

    localparam logic [2:0] IR_BYPASS = 3'b000;
    localparam logic [2:0] IR_REG_OP = 3'b001;
    localparam logic [2:0] IR_RD_MEM = 3'b010;
    localparam logic [2:0] IR_WR_MEM = 3'b011;
    localparam logic [2:0] IR_SETPTR = 3'b100;
    localparam logic [2:0] IR_BWR    = 3'b101;
    localparam logic [2:0] IR_BRD    = 3'b110;
    localparam logic [2:0] IR_UNUSED = 3'b111;

    logic         tck = 1'b0;
    logic         aclr = 1'b0;
    logic         tdi = 1'b0;
    logic [2:0]   ir_in = 3'b000;
    logic         v_sdr = 1'b0, v_cdr = 1'b0, v_udr = 1'b0, v_uir = 1'b0;
    logic         tdo;
    logic         mem_we;
    logic [18:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [7:0]   mem_rdata = 8'h00;
    logic         hw_busy = 1'b0, hw_done = 1'b0;
    logic [127:0] cfg_regs;
    logic         start_pulse;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           pulse_cnt = 0;
    logic [7:0]   pulse_reg = 8'h00;

    logic [7:0]   tbmem [4096];

    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wlog [$];

    typedef struct {
        logic [7:0] idx;
        logic [7:0] data;
        logic       busy;
        logic       done;
        logic [7:0] exp_stat;
        int         slot;
        logic [7:0] exp_reg;
    } regop_vec_t;
    regop_vec_t vt [6];

    jtag_burst_bridge #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NREGS     (NREGS),
        .START_IDX (START_IDX)
    ) dut (
        .tck         (tck),
        .aclr        (aclr),
        .tdi         (tdi),
        .ir_in       (ir_in),
        .v_sdr       (v_sdr),
        .v_cdr       (v_cdr),
        .v_udr       (v_udr),
        .v_uir       (v_uir),
        .tdo         (tdo),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .hw_busy     (hw_busy),
        .hw_done     (hw_done),
        .cfg_regs    (cfg_regs),
        .start_pulse (start_pulse)
    );

    always #5 tck = ~tck;

    // Memory model: read data follows the address by one tck
    always @(posedge tck) mem_rdata <= tbmem[mem_addr[11:0]];

    // Write / pulse monitor, sampled on the inactive edge
    always @(negedge tck) begin
        if (aclr) begin
            if (mem_we) begin
                wlog.push_back(wr_t'{mem_addr, mem_wdata});
                tbmem[mem_addr[11:0]] = mem_wdata;
            end
            if (start_pulse) begin
                pulse_cnt++;
                pulse_reg = cfg_regs[START_IDX*8 +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_wr(input string name, input int k, input logic [18:0] a, input logic [7:0] d);
        wr_t got;
        got = '0;
        if (k < wlog.size()) got = wlog[k];
        check(name, 128'(got), 128'({a, d}));
    endtask

    task automatic step(input logic sdr, input logic cdr, input logic udr, input logic uir, input logic t);
        @(negedge tck);
        v_sdr = sdr; v_cdr = cdr; v_udr = udr; v_uir = uir; tdi = t;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_ir(input logic [2:0] code);
        @(negedge tck);
        ir_in = code;
        v_sdr = 1'b0; v_cdr = 1'b0; v_udr = 1'b0; v_uir = 1'b1; tdi = 1'b0;
        #1;
        idle(1);
    endtask

    // Capture, shift len bits LSB-first, exit, update
    task automatic scan_dr(input int len, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, din[i]);
            dout[i] = tdo;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Capture and stream without an update; we_mask[i] is mem_we seen while
    // shifting bit i, we_mask[nbits] is mem_we on the exit tck
    task automatic burst(input int nbits, input logic [31:0] din,
                         output logic [31:0] dout, output logic [63:0] we_mask);
        dout    = '0;
        we_mask = '0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, din[i]);
            dout[i]    = tdo;
            we_mask[i] = mem_we;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        we_mask[nbits] = mem_we;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        logic [63:0] wm;
        logic [7:0]  prev_idx;

        for (int i = 0; i < 4096; i++) tbmem[i] = 8'h00;

        //            idx    data   busy  done  stat   slot reg
        vt[0] = '{8'h00, 8'h40, 1'b0, 1'b0, 8'h00, 0,  8'h40};
        vt[1] = '{8'h03, 8'h5A, 1'b1, 1'b0, 8'h01, 3,  8'h5A};
        vt[2] = '{8'h0F, 8'hC3, 1'b0, 1'b1, 8'h02, 15, 8'hC3};
        vt[3] = '{8'h10, 8'h77, 1'b1, 1'b1, 8'h03, 0,  8'h40};  // out of range
        vt[4] = '{8'hFF, 8'h12, 1'b0, 1'b0, 8'h00, 15, 8'hC3};  // clear-err index
        vt[5] = '{8'h00, 8'h41, 1'b1, 1'b0, 8'h01, 0,  8'h41};

        // ---------------- reset state ----------------
        repeat (3) @(negedge tck);
        #1;
        check("rst_tdo", 128'(tdo), 128'(0));
        check("rst_mem_we", 128'(mem_we), 128'(0));
        check("rst_start_pulse", 128'(start_pulse), 128'(0));
        check("rst_cfg_regs", cfg_regs, 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        @(negedge tck);
        aclr = 1'b1;
        idle(2);

        // ---------------- REG_OP table ----------------
        set_ir(IR_REG_OP);
        prev_idx = 8'h00;
        for (int i = 0; i < 6; i++) begin
            hw_busy = vt[i].busy;
            hw_done = vt[i].done;
            scan_dr(16, {16'h0, vt[i].idx, vt[i].data}, d);
            check($sformatf("regop_status[%0d]", i), 128'(d[7:0]), 128'(vt[i].exp_stat));
            check($sformatf("regop_idx_kept[%0d]", i), 128'(d[15:8]), 128'(prev_idx));
            check($sformatf("regop_cfg[%0d]", i), 128'(cfg_regs[vt[i].slot*8 +: 8]), 128'(vt[i].exp_reg));
            prev_idx = vt[i].idx;
        end
        hw_busy = 1'b0;
        hw_done = 1'b0;

        // ---------------- WRITE_MEM / READ_MEM ----------------
        set_ir(IR_WR_MEM);
        wlog.delete();
        scan_dr(27, 32'({19'h00010, 8'hA5}), d);
        check("wrmem_count", 128'(wlog.size()), 128'(1));
        check_wr("wrmem_word", 0, 19'h00010, 8'hA5);
        set_ir(IR_RD_MEM);
        wlog.delete();
        scan_dr(27, 32'({19'h00010, 8'h00}), d);
        scan_dr(27, 32'({19'h00010, 8'h00}), d);
        check("rdmem_data", 128'(d[7:0]), 128'(8'hA5));
        check("rdmem_addr", 128'(d[26:8]), 128'(19'h00010));
        check("rdmem_no_we", 128'(wlog.size()), 128'(0));

        // ---------------- BURST_WR 4 words ----------------
        set_ir(IR_SETPTR);
        scan_dr(19, 32'h100, d);
        set_ir(IR_BWR);
        wlog.delete();
        burst(32, 32'h44332211, d, wm);
        check("bwr_we_timing", 128'(wm), 128'(64'h1_0101_0100));
        check("bwr_count", 128'(wlog.size()), 128'(4));
        check_wr("bwr_w0", 0, 19'h00100, 8'h11);
        check_wr("bwr_w1", 1, 19'h00101, 8'h22);
        check_wr("bwr_w2", 2, 19'h00102, 8'h33);
        check_wr("bwr_w3", 3, 19'h00103, 8'h44);
        set_ir(IR_SETPTR);
        scan_dr(19, 32'h104, d);
        check("bwr_ptr_after", 128'(d[18:0]), 128'(19'h00104));

        // ---------------- BURST_RD 4 words ----------------
        tbmem[12'h200] = 8'h01;
        tbmem[12'h201] = 8'h02;
        tbmem[12'h202] = 8'h03;
        tbmem[12'h203] = 8'h04;
        scan_dr(19, 32'h200, d);
        set_ir(IR_BRD);
        burst(32, 32'h0, d, wm);
        check("brd_stream", 128'(d), 128'(32'h04030201));
        check("brd_no_we", 128'(wm), 128'(0));

        // ---------------- pointer wrap + sticky err ----------------
        set_ir(IR_SETPTR);
        scan_dr(19, 32'(MMIO_BASE - 19'd1), d);
        set_ir(IR_BWR);
        wlog.delete();
        burst(16, 32'h0000BBAA, d, wm);
        check("wrap_count", 128'(wlog.size()), 128'(2));
        check_wr("wrap_w0", 0, MMIO_BASE - 19'd1, 8'hAA);
        check_wr("wrap_w1", 1, 19'h00000, 8'hBB);
        set_ir(IR_REG_OP);
        scan_dr(16, 32'hFF00, d);
        check("wrap_err_set", 128'(d[7:0]), 128'(8'h04));
        scan_dr(16, 32'hFE00, d);
        check("err_cleared", 128'(d[7:0]), 128'(8'h00));

        // SET_PTR into the MMIO window clamps to 0 and flags err
        set_ir(IR_SETPTR);
        scan_dr(19, 32'(MMIO_BASE), d);
        scan_dr(19, 32'h0, d);
        check("setptr_clamp", 128'(d[18:0]), 128'(0));
        set_ir(IR_REG_OP);
        scan_dr(16, 32'hFF00, d);
        check("setptr_err", 128'(d[7:0]), 128'(8'h04));

        // ---------------- MMIO write via WRITE_MEM ----------------
        set_ir(IR_WR_MEM);
        wlog.delete();
        pulse_cnt = 0;
        pulse_reg = 8'h00;
        scan_dr(27, 32'({MMIO_BASE + 19'd6, 8'h01}), d);
        idle(2);
        check("mmio_no_we", 128'(wlog.size()), 128'(0));
        check("mmio_reg6", 128'(cfg_regs[55:48]), 128'(8'h01));
        check("mmio_pulse_count", 128'(pulse_cnt), 128'(1));
        check("mmio_pulse_with_reg", 128'(pulse_reg), 128'(8'h01));
        scan_dr(27, 32'({MMIO_BASE + 19'd6, 8'h02}), d);
        idle(2);
        check("mmio_bit0_clear_no_pulse", 128'(pulse_cnt), 128'(1));
        check("mmio_reg6_b", 128'(cfg_regs[55:48]), 128'(8'h02));
        set_ir(IR_REG_OP);
        scan_dr(16, 32'h0603, d);
        idle(2);
        check("regop_pulse_count", 128'(pulse_cnt), 128'(2));

        // ---------------- BYPASS (000 and 111) ----------------
        set_ir(IR_BYPASS);
        scan_dr(4, 32'hB, d);
        check("bypass_000", 128'(d[3:0]), 128'(4'b0110));
        set_ir(IR_UNUSED);
        scan_dr(4, 32'h5, d);
        check("bypass_111", 128'(d[3:0]), 128'(4'b1010));

        // ---------------- v_uir mid-burst clears bcnt ----------------
        set_ir(IR_SETPTR);
        scan_dr(19, 32'h300, d);
        set_ir(IR_BWR);
        wlog.delete();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        set_ir(IR_BWR);
        d = 32'h5C;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, d[i]);
        idle(2);
        check("uir_count", 128'(wlog.size()), 128'(1));
        check_wr("uir_word", 0, 19'h00300, 8'h5C);

        // ---------------- reset mid-burst ----------------
        wlog.delete();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        aclr = 1'b0;                          // lands before the final-bit edge
        #20;
        v_sdr = 1'b0;
        tdi   = 1'b0;
        @(negedge tck);
        aclr = 1'b1;
        idle(3);
        check("rst_burst_no_we", 128'(wlog.size()), 128'(0));
        check("rst_burst_cfg", cfg_regs, 128'(0));
        set_ir(IR_SETPTR);
        scan_dr(19, 32'h0, d);
        check("rst_burst_ptr", 128'(d[18:0]), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
